// File: rtl/fire_expand3_sequencer.sv
// Sequences one expand3 layer at a time (fire4 or fire5) over a shared MAC array:
// a weight-ROM address sweep per output pixel, a clear/capture cycle per window, then ack handshake.
module fire_expand3_sequencer #(
  parameter  int KERNEL_DIM = 3,
  parameter  int CHIN       = 32,
  parameter  int WOUT       = 32,
  localparam int N          = KERNEL_DIM * KERNEL_DIM * CHIN,
  localparam int P          = WOUT * WOUT,
  localparam int AW         = $clog2(N),
  localparam int PW         = $clog2(P) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start4,
  input  logic          start5,
  input  logic          ack4,
  input  logic          ack5,
  output logic          layer_sel,
  output logic          layer_en,
  output logic [AW-1:0] rom_addr,
  output logic          mac_clr,
  output logic          sample,
  output logic [PW-1:0] pix_cnt,
  output logic          finish4,
  output logic          finish5,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t state, state_nxt;
  logic   done4_flag, done5_flag;
  logic   req4, req5;

  always_comb begin
    req4 = start4 && !done4_flag;
    req5 = start5 && !done5_flag;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req4 || req5) state_nxt = RUN;
      // the clear cycle that completes the last pixel ends the sweep
      RUN:     if (mac_clr && pix_cnt == PW'(P - 1)) state_nxt = FLUSH;
      FLUSH:   state_nxt = DONE;
      DONE:    if (layer_sel ? ack5 : ack4) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    layer_en = (state == RUN);
    busy     = (state != IDLE);
    finish4  = (state == DONE) && !layer_sel;
    finish5  = (state == DONE) &&  layer_sel;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      layer_sel  <= 1'b0;
      rom_addr   <= '0;
      mac_clr    <= 1'b0;
      sample     <= 1'b0;
      pix_cnt    <= '0;
      done4_flag <= 1'b0;
      done5_flag <= 1'b0;
    end else begin
      sample  <= mac_clr;
      mac_clr <= 1'b0;
      case (state)
        IDLE: begin
          if (req4 || req5) begin
            layer_sel <= !req4;
            rom_addr  <= '0;
            pix_cnt   <= '0;
          end
        end
        RUN: begin
          // window = N address cycles plus one clear cycle at address 0
          if (mac_clr) begin
            rom_addr <= '0;
            pix_cnt  <= pix_cnt + PW'(1);
          end else if (rom_addr == AW'(N - 1)) begin
            rom_addr <= '0;
            mac_clr  <= 1'b1;
          end else begin
            rom_addr <= rom_addr + AW'(1);
          end
        end
        DONE: begin
          if (!layer_sel && ack4) done4_flag <= 1'b1;
          if ( layer_sel && ack5) done5_flag <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
